// File: rtl/rom_word_fetch.sv
// Read controller for an 8-bit asynchronous ROM: fetches the even/odd byte pair
// of a word address, holding each byte address for wait_states+1 clocks.
`timescale 1ns/1ps
module rom_word_fetch #(
    parameter int bits        = 13,
    parameter int wait_states = 2
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            req,
    input  logic [bits-2:0] addr,
    output logic            busy,
    output logic            valid,
    output logic [15:0]     dout,
    output logic [bits-1:0] rom_a,
    output logic            rom_nce,
    output logic            rom_noe,
    input  logic [7:0]      rom_d
);

    typedef enum logic [1:0] {IDLE, HI, LO} state_t;

    localparam logic [3:0] WS = 4'(wait_states);

    state_t          state, state_n;
    logic [3:0]      cnt, cnt_n;
    logic [bits-2:0] areg, areg_n;
    logic [7:0]      hi_lat, hi_lat_n;
    logic [15:0]     dout_n;
    logic            valid_n;
    logic [bits-1:0] rom_a_n;
    logic            rom_nce_n, rom_noe_n;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            areg    <= '0;
            hi_lat  <= 8'h00;
            dout    <= 16'h0000;
            valid   <= 1'b0;
            rom_a   <= '0;
            rom_nce <= 1'b1;
            rom_noe <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            areg    <= areg_n;
            hi_lat  <= hi_lat_n;
            dout    <= dout_n;
            valid   <= valid_n;
            rom_a   <= rom_a_n;
            rom_nce <= rom_nce_n;
            rom_noe <= rom_noe_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        areg_n    = areg;
        hi_lat_n  = hi_lat;
        dout_n    = dout;
        valid_n   = 1'b0;
        rom_a_n   = rom_a;
        rom_nce_n = rom_nce;
        rom_noe_n = rom_noe;
        case (state)
            IDLE: begin
                if (req) begin
                    areg_n    = addr;
                    rom_a_n   = {addr, 1'b0};
                    cnt_n     = WS;
                    rom_nce_n = 1'b0;
                    rom_noe_n = 1'b0;
                    state_n   = HI;
                end else begin
                    rom_nce_n = 1'b1;
                    rom_noe_n = 1'b1;
                end
            end
            HI: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    hi_lat_n = rom_d;
                    rom_a_n  = {areg, 1'b1};
                    cnt_n    = WS;
                    state_n  = LO;
                end
            end
            LO: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    dout_n    = {hi_lat, rom_d};
                    valid_n   = 1'b1;
                    // A pending back-to-back request keeps the ROM enabled
                    // through the hand-off cycle; IDLE releases it otherwise.
                    rom_nce_n = ~req;
                    rom_noe_n = ~req;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_rom_word_fetch.sv
// Directed bench for rom_word_fetch: three instances (W=2, W=0, W=15), each
// driving its own 70ns-access asynchronous ROM model sharing one image.
`timescale 1ns/1ps
module tb_rom_word_fetch;

    logic        clk;
    logic        nreset;
    logic        req2, req0, req15;
    logic [11:0] addr;

    logic        busy2, valid2, nce2, noe2;
    logic [15:0] dout2;
    logic [12:0] a2;
    logic [7:0]  d2;
    logic        busy0, valid0, nce0, noe0;
    logic [15:0] dout0;
    logic [12:0] a0;
    logic [7:0]  d0;
    logic        busy15, valid15, nce15, noe15;
    logic [15:0] dout15;
    logic [12:0] a15;
    logic [7:0]  d15;

    logic [7:0] mem [0:8191];
    int vectors = 0;
    int miscompares = 0;

    rom_word_fetch #(.bits(13), .wait_states(2)) dut2 (
        .clk(clk), .nreset(nreset), .req(req2), .addr(addr), .busy(busy2),
        .valid(valid2), .dout(dout2), .rom_a(a2), .rom_nce(nce2),
        .rom_noe(noe2), .rom_d(d2));
    rom_word_fetch #(.bits(13), .wait_states(0)) dut0 (
        .clk(clk), .nreset(nreset), .req(req0), .addr(addr), .busy(busy0),
        .valid(valid0), .dout(dout0), .rom_a(a0), .rom_nce(nce0),
        .rom_noe(noe0), .rom_d(d0));
    rom_word_fetch #(.bits(13), .wait_states(15)) dut15 (
        .clk(clk), .nreset(nreset), .req(req15), .addr(addr), .busy(busy15),
        .valid(valid15), .dout(dout15), .rom_a(a15), .rom_nce(nce15),
        .rom_noe(noe15), .rom_d(d15));

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Output goes unknown on any control/address change, settles after tacc.
    always @(a2 or nce2 or noe2) begin
        d2 = 8'hxx;
        #70;
        d2 = (!nce2 && !noe2) ? mem[a2] : 8'hzz;
    end
    always @(a0 or nce0 or noe0) begin
        d0 = 8'hxx;
        #70;
        d0 = (!nce0 && !noe0) ? mem[a0] : 8'hzz;
    end
    always @(a15 or nce15 or noe15) begin
        d15 = 8'hxx;
        #70;
        d15 = (!nce15 && !noe15) ? mem[a15] : 8'hzz;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        mem[13'h0100] = 8'h12;
        mem[13'h0101] = 8'h34;
        mem[13'h0102] = 8'hAB;
        mem[13'h0103] = 8'hCD;
        mem[13'h1FFE] = 8'hDE;
        mem[13'h1FFF] = 8'hAD;

        nreset = 1'b0;
        req2 = 1'b0; req0 = 1'b0; req15 = 1'b0;
        addr = 12'h080;

        // reset held while req toggles
        repeat (4) begin
            @(negedge clk);
            req2 = ~req2; req0 = ~req0; req15 = ~req15;
        end
        cyc(1);
        chk("rst_nce", nce2, 1);
        chk("rst_noe", noe2, 1);
        chk("rst_rom_a", a2, 0);
        chk("rst_dout", dout2, 0);
        chk("rst_valid", valid2, 0);
        chk("rst_busy", busy2, 0);
        req2 = 1'b0; req0 = 1'b0; req15 = 1'b0;
        nreset = 1'b1;
        cyc(3);
        chk("idle_busy", busy2, 0);
        chk("idle_valid", valid2, 0);
        chk("idle_nce", nce2, 1);
        chk("idle_rom_a", a2, 0);

        // single fetch, W=2
        addr = 12'h080; req2 = 1'b1;
        cyc(1);
        req2 = 1'b0;
        chk("w2_busy", busy2, 1);
        chk("w2_nce", nce2, 0);
        chk("w2_noe", noe2, 0);
        for (int k = 0; k < 6; k++) begin
            chk("w2_rom_a", a2, (k < 3) ? 13'h0100 : 13'h0101);
            chk("w2_valid_lo", valid2, 0);
            chk("w2_nce_hold", nce2, 0);
            cyc(1);
        end
        chk("w2_valid", valid2, 1);
        chk("w2_dout", dout2, 16'h1234);
        chk("w2_busy_fall", busy2, 0);
        chk("w2_nce_rel", nce2, 1);
        cyc(1);
        chk("w2_valid_clr", valid2, 0);
        chk("w2_dout_hold", dout2, 16'h1234);

        // W=0: one cycle per byte
        req0 = 1'b1;
        cyc(1);
        req0 = 1'b0;
        chk("w0_rom_a_hi", a0, 13'h0100);
        chk("w0_valid_lo", valid0, 0);
        cyc(1);
        chk("w0_rom_a_lo", a0, 13'h0101);
        chk("w0_valid_lo2", valid0, 0);
        cyc(1);
        chk("w0_valid", valid0, 1);
        chk("w0_dout", dout0, 16'h1234);

        // W=15
        req15 = 1'b1;
        cyc(1);
        req15 = 1'b0;
        cyc(15);
        chk("w15_rom_a_hi", a15, 13'h0100);
        cyc(1);
        chk("w15_rom_a_lo", a15, 13'h0101);
        cyc(15);
        chk("w15_valid_lo", valid15, 0);
        cyc(1);
        chk("w15_valid", valid15, 1);
        chk("w15_dout", dout15, 16'h1234);

        // back-to-back with req held high
        addr = 12'h080; req2 = 1'b1;
        cyc(1);
        addr = 12'h081;
        for (int k = 0; k < 6; k++) begin
            chk("b2b_nce_a", nce2, 0);
            chk("b2b_valid_a", valid2, 0);
            cyc(1);
        end
        chk("b2b_valid1", valid2, 1);
        chk("b2b_dout1", dout2, 16'h1234);
        chk("b2b_nce_gap", nce2, 0);
        cyc(1);
        req2 = 1'b0;
        chk("b2b_rom_a2", a2, 13'h0102);
        chk("b2b_busy2", busy2, 1);
        for (int k = 7; k < 13; k++) begin
            chk("b2b_nce_b", nce2, 0);
            chk("b2b_valid_b", valid2, 0);
            cyc(1);
        end
        chk("b2b_valid2", valid2, 1);
        chk("b2b_dout2", dout2, 16'hABCD);
        chk("b2b_nce_end", nce2, 1);

        // req while busy is ignored
        cyc(1);
        addr = 12'h080; req2 = 1'b1;
        cyc(1);
        req2 = 1'b0;
        cyc(2);
        addr = 12'h7FF; req2 = 1'b1;
        cyc(1);
        req2 = 1'b0;
        chk("ign_rom_a", a2, 13'h0101);
        cyc(3);
        chk("ign_valid", valid2, 1);
        chk("ign_dout", dout2, 16'h1234);
        cyc(1);
        chk("ign_busy", busy2, 0);
        for (int k = 0; k < 3; k++) begin
            chk("ign_no_valid", valid2, 0);
            cyc(1);
        end

        // address wrap
        addr = 12'hFFF; req2 = 1'b1;
        cyc(1);
        req2 = 1'b0;
        chk("wrap_rom_a_hi", a2, 13'h1FFE);
        cyc(3);
        chk("wrap_rom_a_lo", a2, 13'h1FFF);
        cyc(3);
        chk("wrap_valid", valid2, 1);
        chk("wrap_dout", dout2, 16'hDEAD);

        // reset during LO
        cyc(1);
        addr = 12'h081; req2 = 1'b1;
        cyc(1);
        req2 = 1'b0;
        cyc(4);
        chk("mrst_in_lo", a2, 13'h0103);
        nreset = 1'b0;
        #1;
        chk("mrst_nce", nce2, 1);
        chk("mrst_noe", noe2, 1);
        chk("mrst_dout", dout2, 0);
        chk("mrst_valid", valid2, 0);
        chk("mrst_busy", busy2, 0);
        chk("mrst_rom_a", a2, 0);
        @(negedge clk);
        nreset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc(1);
            chk("mrst_no_valid", valid2, 0);
            chk("mrst_dout_hold", dout2, 0);
        end
        addr = 12'h080; req2 = 1'b1;
        cyc(1);
        req2 = 1'b0;
        cyc(6);
        chk("mrst_refetch_valid", valid2, 1);
        chk("mrst_refetch_dout", dout2, 16'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
